// File: rtl/count_tracker_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : count_tracker_pkg                                         |
// | Description : Shared types and constants for the count tracker:          |
// |               FSM state, delta classification and wrap-stat limits.     |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
package count_tracker_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        D_HOLD = 2'd0,
        D_INC  = 2'd1,
        D_DEC  = 2'd2,
        D_JUMP = 2'd3
    } delta_t;

    localparam int WRAP_CNT_MAX = 255;

    // Saturating 8-bit increment used by the optional wrap statistics
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(WRAP_CNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_tracker_delta_cls.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : cnt_delta_cls                                             |
// | Description : Combinational classifier of the modular step between the  |
// |               previous and current counter samples, plus flags for the  |
// |               max->0 and 0->max wrap boundaries.                        |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module cnt_delta_cls
    import count_tracker_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] prev,
    input  logic [CNT_W-1:0] cnt_in,
    output delta_t           cls,
    output logic             at_wrap_up,
    output logic             at_wrap_dn
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] w_delta;

    // Modular difference naturally wraps in CNT_W bits
    assign w_delta = cnt_in - prev;

    // Map the step size onto one of the four tracking actions
    always_comb begin
        cls = D_JUMP;
        if (w_delta == '0) begin
            cls = D_HOLD;
        end else if (w_delta == C_CNT_ONE) begin
            cls = D_INC;
        end else if (w_delta == C_CNT_MAX) begin
            cls = D_DEC;
        end
    end

    assign at_wrap_up = (prev == C_CNT_MAX) && (cnt_in == '0);
    assign at_wrap_dn = (prev == '0) && (cnt_in == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/count_tracker.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : count_tracker                                             |
// | Description : Observes a narrow up/down/load counter, infers direction, |
// |               extends it into a wide wrap-aware count and flags wraps   |
// |               and unqualified jumps. Optional wrap statistics port is   |
// |               enabled with COUNT_TRACKER_WRAP_STATS_EN.                 |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module count_tracker
    import count_tracker_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int EXT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             cnt_clr,
    input  logic             cnt_ld,
    output logic [EXT_W-1:0] ext_cnt,
    output logic             valid,
    output logic             dir,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             jump_err
`ifdef COUNT_TRACKER_WRAP_STATS_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    localparam int C_PAD_W = EXT_W - CNT_W;

    state_t           r_state;
    logic [CNT_W-1:0] r_prev;
    logic [EXT_W-1:0] r_ext;
    logic             r_valid;
    logic             r_dir;
    logic             r_wrap_up;
    logic             r_wrap_dn;
    logic             r_jump_err;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
    logic [7:0]       r_wrap_cnt;
`endif

    delta_t           w_cls;
    logic             w_at_wrap_up;
    logic             w_at_wrap_dn;
    logic [EXT_W-1:0] w_ext_load;

    cnt_delta_cls #(
        .CNT_W (CNT_W)
    ) u_delta_cls (
        .prev       (r_prev),
        .cnt_in     (cnt_in),
        .cls        (w_cls),
        .at_wrap_up (w_at_wrap_up),
        .at_wrap_dn (w_at_wrap_dn)
    );

    // A load or resync replaces only the low bits; the history above is kept
    assign w_ext_load = {r_ext[EXT_W-1:CNT_W], cnt_in};

    // Tracking FSM and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_ext      <= '0;
            r_valid    <= 1'b0;
            r_dir      <= 1'b1;
            r_wrap_up  <= 1'b0;
            r_wrap_dn  <= 1'b0;
            r_jump_err <= 1'b0;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
            r_wrap_cnt <= '0;
`endif
        end else begin
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_prev  <= cnt_in;
                    r_ext   <= {{C_PAD_W{1'b0}}, cnt_in};
                    r_valid <= 1'b1;
                    r_state <= TRACK;
                end
                TRACK: begin
                    r_prev <= cnt_in;
                    if (cnt_clr) begin
                        r_ext      <= '0;
                        r_jump_err <= 1'b0;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
                        r_wrap_cnt <= '0;
`endif
                    end else if (cnt_ld) begin
                        r_ext <= w_ext_load;
                    end else begin
                        case (w_cls)
                            D_HOLD: begin
                            end
                            D_INC: begin
                                r_ext     <= r_ext + EXT_W'(1);
                                r_dir     <= 1'b1;
                                r_wrap_up <= w_at_wrap_up;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
                                if (w_at_wrap_up) r_wrap_cnt <= sat_inc8(r_wrap_cnt);
`endif
                            end
                            D_DEC: begin
                                r_ext     <= r_ext - EXT_W'(1);
                                r_dir     <= 1'b0;
                                r_wrap_dn <= w_at_wrap_dn;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
                                if (w_at_wrap_dn) r_wrap_cnt <= sat_inc8(r_wrap_cnt);
`endif
                            end
                            default: begin
                                r_jump_err <= 1'b1;
                                r_ext      <= w_ext_load;
                            end
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ext_cnt  = r_ext;
    assign valid    = r_valid;
    assign dir      = r_dir;
    assign wrap_up  = r_wrap_up;
    assign wrap_dn  = r_wrap_dn;
    assign jump_err = r_jump_err;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
    assign wrap_cnt = r_wrap_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_tracker.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_count_tracker                                          |
// | Description : Self-checking bench for count_tracker: directed scenarios |
// |               with literal expectations plus randomized stimulus, all   |
// |               compared each cycle against an arithmetic reference.      |
// |               Wrap statistics are exercised when                        |
// |               COUNT_TRACKER_WRAP_STATS_EN is defined.                   |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_count_tracker;

    localparam int CNT_W = 4;
    localparam int EXT_W = 12;
    localparam int C_CMASK = (1 << CNT_W) - 1;
    localparam int C_EMASK = (1 << EXT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] cnt_in = '0;
    logic             cnt_clr = 1'b0;
    logic             cnt_ld = 1'b0;
    logic [EXT_W-1:0] ext_cnt;
    logic             valid;
    logic             dir;
    logic             wrap_up;
    logic             wrap_dn;
    logic             jump_err;
`ifdef COUNT_TRACKER_WRAP_STATS_EN
    logic [7:0]       wrap_cnt;
`endif

    count_tracker #(
        .CNT_W (CNT_W),
        .EXT_W (EXT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .cnt_clr  (cnt_clr),
        .cnt_ld   (cnt_ld),
        .ext_cnt  (ext_cnt),
        .valid    (valid),
        .dir      (dir),
        .wrap_up  (wrap_up),
        .wrap_dn  (wrap_dn),
        .jump_err (jump_err)
`ifdef COUNT_TRACKER_WRAP_STATS_EN
        ,
        .wrap_cnt (wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: "started" means the first post-reset sample has been taken
    bit m_started = 1'b0;
    int m_prev = 0;
    int m_ext = 0;
    int m_valid = 0;
    int m_dir = 1;
    int m_wu = 0;
    int m_wd = 0;
    int m_jump = 0;
    int m_wcnt = 0;

    always @(posedge clk or posedge rst) begin
        int c;
        int d;
        if (rst) begin
            m_started = 1'b0;
            m_prev = 0; m_ext = 0; m_valid = 0; m_dir = 1;
            m_wu = 0; m_wd = 0; m_jump = 0; m_wcnt = 0;
        end else begin
            c = int'(cnt_in);
            m_wu = 0;
            m_wd = 0;
            if (!m_started) begin
                m_started = 1'b1;
                m_ext = c;
                m_valid = 1;
            end else begin
                d = (c - m_prev) & C_CMASK;
                if (cnt_clr) begin
                    m_ext = 0;
                    m_jump = 0;
                    m_wcnt = 0;
                end else if (cnt_ld) begin
                    m_ext = (m_ext & ~C_CMASK) | c;
                end else if (d == 0) begin
                    // no change
                end else if (d == 1) begin
                    m_ext = (m_ext + 1) & C_EMASK;
                    m_dir = 1;
                    m_wu = (m_prev == C_CMASK && c == 0) ? 1 : 0;
                end else if (d == C_CMASK) begin
                    m_ext = (m_ext - 1) & C_EMASK;
                    m_dir = 0;
                    m_wd = (m_prev == 0 && c == C_CMASK) ? 1 : 0;
                end else begin
                    m_jump = 1;
                    m_ext = (m_ext & ~C_CMASK) | c;
                end
                if ((m_wu | m_wd) != 0 && m_wcnt < 255) m_wcnt = m_wcnt + 1;
            end
            m_prev = c;
        end
    end

    // Cycle-by-cycle comparison of every output against the reference
    always @(negedge clk) begin
        check("ext_cnt", int'(ext_cnt), m_ext);
        check("valid", int'(valid), m_valid);
        check("dir", int'(dir), m_dir);
        check("wrap_up", int'(wrap_up), m_wu);
        check("wrap_dn", int'(wrap_dn), m_wd);
        check("jump_err", int'(jump_err), m_jump);
        check("wrap_excl", int'(wrap_up & wrap_dn), 0);
`ifdef COUNT_TRACKER_WRAP_STATS_EN
        check("wrap_cnt", int'(wrap_cnt), m_wcnt);
`endif
    end

    // Drive one sample (called at a falling edge) and return at the next falling edge
    task automatic step(input int c, input bit clr, input bit ld);
        cnt_in  = CNT_W'(c & C_CMASK);
        cnt_clr = clr;
        cnt_ld  = ld;
        @(negedge clk);
    endtask

    int cur;
    int r;
    int r2;
    int nxt;
    bit rc;
    bit rl;

    initial begin
        #1 rst = 1'b1;
        cnt_in = 4'h3;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", int'(valid), 0);
        check("rst_dir", int'(dir), 1);
        rst = 1'b0;
        step(3, 0, 0);
        check("idle_ext", int'(ext_cnt), 'h003);
        check("idle_valid", int'(valid), 1);
        check("idle_dir", int'(dir), 1);
        check("idle_pulse", int'(wrap_up | wrap_dn), 0);

        // Count up to E, then E,F,0,1
        for (int v = 4; v <= 14; v++) step(v, 0, 0);
        check("up_to_E", int'(ext_cnt), 'h00E);
        step('hF, 0, 0);
        check("up_F_nowrap", int'(wrap_up), 0);
        step(0, 0, 0);
        check("up_wrap_pulse", int'(wrap_up), 1);
        check("up_wrap_ext", int'(ext_cnt), 'h010);
        step(1, 0, 0);
        check("up_wrap_gone", int'(wrap_up), 0);
        check("up_ext_011", int'(ext_cnt), 'h011);

        // Count down 1,0,F
        step(1, 0, 0);
        step(0, 0, 0);
        check("dn_ext_010", int'(ext_cnt), 'h010);
        step('hF, 0, 0);
        check("dn_wrap_pulse", int'(wrap_dn), 1);
        check("dn_ext_00F", int'(ext_cnt), 'h00F);
        check("dn_dir", int'(dir), 0);
        step('hF, 0, 0);
        check("dn_wrap_gone", int'(wrap_dn), 0);

        // Reach 0x013 then load A
        for (int v = 0; v <= 3; v++) step(v, 0, 0);
        check("pre_load_ext", int'(ext_cnt), 'h013);
        step('hA, 0, 1);
        check("load_ext", int'(ext_cnt), 'h01A);
        check("load_nojump", int'(jump_err), 0);
        check("load_nopulse", int'(wrap_up | wrap_dn), 0);

        // Unqualified jump 2 -> 9, sticky error, then clear
        step(2, 0, 1);
        step(9, 0, 0);
        check("jump_flag", int'(jump_err), 1);
        check("jump_low", int'(ext_cnt) & 'hF, 9);
        step(9, 0, 0);
        step('hA, 0, 0);
        check("jump_sticky", int'(jump_err), 1);
        step(0, 1, 1);
        check("clr_ext", int'(ext_cnt), 0);
        check("clr_jump", int'(jump_err), 0);

        // Count to 0x025 and reset asynchronously between edges
        for (int k = 1; k <= 37; k++) step(k, 0, 0);
        check("pre_rst_ext", int'(ext_cnt), 'h025);
        #2 rst = 1'b1;
        #1;
        check("async_ext", int'(ext_cnt), 0);
        check("async_valid", int'(valid), 0);
        check("async_dir", int'(dir), 1);
        @(negedge clk);
        rst = 1'b0;
        cur = 5;
        step(cur, 0, 0);
        check("restart_ext", int'(ext_cnt), 5);

`ifdef COUNT_TRACKER_WRAP_STATS_EN
        for (int w = 0; w < 300; w++) begin
            for (int k = 1; k <= 16; k++) step(cur + k, 0, 0);
        end
        check("wrap_cnt_sat", int'(wrap_cnt), 255);
        step(0, 1, 0);
        check("wrap_cnt_clr", int'(wrap_cnt), 0);
        cur = 0;
`endif

        // Randomized mix of counting, holds, jumps, qualifiers and resets
        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            rc = (r < 3);
            rl = (r >= 3 && r < 9);
            if (rc) nxt = (r2 < 80) ? 0 : $urandom_range(0, 15);
            else if (rl) nxt = $urandom_range(0, 15);
            else if (r2 < 55) nxt = cur + 1;
            else if (r2 < 80) nxt = cur - 1;
            else if (r2 < 90) nxt = cur;
            else nxt = $urandom_range(0, 15);
            cur = nxt & C_CMASK;
            if ($urandom_range(0, 199) == 0) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            step(cur, rc, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
